// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, arbiter state encoding and requester IDs for the L1/L2 slice.
package cache_pkg;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that sticks at all-ones.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [15:0] o_cnt
);
  logic [15:0] r_cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_cnt <= '0;
    else r_cnt <= (i_en && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares the L2/memory block port between I-cache and D-cache miss paths.
module l2_mem_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int DATA_W = cache_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       gnt_cnt_i,
  output logic [15:0]       gnt_cnt_d
);
  state_t r_state, w_next;
  logic r_last, r_proto_err, r_mem_read, r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic w_idle, w_gnt_i, w_gnt_d, w_done;
  assign w_idle  = r_state == IDLE;
  // On a conflict the side that did not win last time takes the port.
  assign w_gnt_d = w_idle & (d_read | d_write) & (~i_read | (r_last == REQ_I));
  assign w_gnt_i = w_idle & i_read & ~w_gnt_d;
  assign w_done  = ~w_idle & mem_ready;
  always_comb begin
    w_next  = w_gnt_i ? BUSY_I : w_gnt_d ? BUSY_D : w_done ? IDLE : r_state;
    i_ready = w_done & (r_state == BUSY_I);
    d_ready = w_done & (r_state == BUSY_D);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_last      <= REQ_I;
      r_proto_err <= 1'b0;
    end else if (w_gnt_i) begin
      r_mem_read  <= 1'b1;
      r_mem_write <= 1'b0;
      r_mem_addr  <= i_addr;
      r_last      <= REQ_I;
    end else if (w_gnt_d) begin
      // Read+write together is illegal: the write-back wins and the error is latched.
      r_mem_read  <= d_read & ~d_write;
      r_mem_write <= d_write;
      r_mem_addr  <= d_addr;
      r_mem_wdata <= d_wdata;
      r_last      <= REQ_D;
      r_proto_err <= r_proto_err | (d_read & d_write);
    end else if (w_done) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;
  sat_counter16 u_cnt_i (.clk(clk), .rst(rst), .i_en(w_gnt_i), .o_cnt(gnt_cnt_i));
  sat_counter16 u_cnt_d (.clk(clk), .rst(rst), .i_en(w_gnt_d), .o_cnt(gnt_cnt_d));
endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb_l2_mem_arbiter: transaction-level model plus directed scenarios for the L2 port arbiter.
module tb_l2_mem_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, mem_ready = 1'b0;
  logic [27:0] i_addr = '0, d_addr = '0;
  logic [127:0] d_wdata = '0, mem_rdata = '0;
  logic i_ready, d_ready, mem_read, mem_write;
  logic [127:0] i_rdata, d_rdata, mem_wdata;
  logic [27:0] mem_addr;
  logic [15:0] gnt_cnt_i, gnt_cnt_d;
  always #5 clk = ~clk;
  l2_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .gnt_cnt_i(gnt_cnt_i), .gnt_cnt_d(gnt_cnt_d)
  );
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // Model: who owns the port (0 none, 1 I, 2 D), what was sent, and grant tallies.
  int m_busy = 0;
  bit m_last = 0, m_rd = 0, m_wr = 0, m_perr = 0, take_d = 0, load_req = 0, chk_en = 1;
  logic [27:0] m_addr = '0;
  logic [127:0] m_wdata = '0;
  logic [15:0] m_ci = '0, m_cd = '0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_last = 0; m_rd = 0; m_wr = 0; m_perr = 0;
      m_addr = '0; m_wdata = '0; m_ci = '0; m_cd = '0;
    end else begin
      if (load_req) m_cd = 16'hFFFE;
      if (m_busy == 0 && (i_read || d_read || d_write)) begin
        take_d = (d_read || d_write) && (!i_read || !m_last);
        if (take_d) begin
          m_busy = 2; m_wr = d_write; m_rd = d_read && !d_write; m_addr = d_addr;
          m_wdata = d_wdata; m_last = 1; m_perr = m_perr | (d_read && d_write);
          if (m_cd != 16'hFFFF) m_cd = m_cd + 16'd1;
        end else begin
          m_busy = 1; m_rd = 1; m_wr = 0; m_addr = i_addr; m_last = 0;
          if (m_ci != 16'hFFFF) m_ci = m_ci + 16'd1;
        end
      end else if (m_busy != 0 && mem_ready) begin
        m_busy = 0; m_rd = 0; m_wr = 0;
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("i_ready", i_ready, m_busy == 1 && mem_ready);
    chk("d_ready", d_ready, m_busy == 2 && mem_ready);
    chk("mem_read", mem_read, m_rd);
    chk("mem_write", mem_write, m_wr);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("gnt_cnt_i", gnt_cnt_i, m_ci);
    chk("gnt_cnt_d", gnt_cnt_d, m_cd);
    chk("i_rdata", i_rdata, mem_rdata);
    chk("d_rdata", d_rdata, mem_rdata);
    chk("proto_err", dut.r_proto_err, m_perr);
  end
  // Memory: answers any command after three cycles; can also emit a stray pulse.
  int lat_cnt = 0;
  bit stray = 0;
  always @(posedge clk) begin
    #1;
    if (!rst) begin lat_cnt = 0; mem_ready = 0; end
    else if (mem_ready) mem_ready = 0;
    else if (stray) begin mem_ready = 1; mem_rdata = {128{1'b1}}; end
    else if (mem_read || mem_write) begin
      lat_cnt++;
      if (lat_cnt == 3) begin lat_cnt = 0; mem_ready = 1; mem_rdata = {mem_addr, 84'h0, 16'hDEAD}; end
    end
  end
  int n_ir = 0, n_dr = 0, n_mrd = 0, idle_run = 0;
  bit prev_busy = 0;
  int ord[$];
  int gaps[$];
  always @(negedge clk) begin
    if (i_ready) begin n_ir++; ord.push_back(0); end
    if (d_ready) begin n_dr++; ord.push_back(1); end
    if (mem_read) n_mrd++;
    if (mem_read || mem_write) begin
      if (!prev_busy) gaps.push_back(idle_run);
      idle_run = 0;
    end else idle_run++;
    prev_busy = mem_read || mem_write;
  end
  task automatic wait_rdy(input bit d, output logic [127:0] rd);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(d ? d_ready : i_ready) && n < 100);
    chk(d ? "d_ready_seen" : "i_ready_seen", d ? d_ready : i_ready, 1);
    rd = mem_rdata;
    @(posedge clk); #1;
  endtask
  task automatic run_i(input logic [27:0] a);
    logic [127:0] rd;
    i_addr = a; i_read = 1;
    wait_rdy(0, rd);
    i_read = 0;
  endtask
  task automatic run_d(input logic [27:0] a, input logic [127:0] w, input bit rdq, input bit wrq);
    logic [127:0] rd;
    d_addr = a; d_wdata = w; d_read = rdq; d_write = wrq;
    wait_rdy(1, rd);
    d_read = 0; d_write = 0;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete at %0t", $time);
    $fatal(1);
  end
  logic [127:0] rdv;
  int b0, b1, b2, bo, bg;
  logic [15:0] sci, scd;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_gnt_cnt_i", gnt_cnt_i, 0);
    chk("rst_i_ready", i_ready, 0);
    rst = 1;
    @(posedge clk); #1;
    b0 = n_ir;
    i_addr = 28'h0000010; i_read = 1;
    @(posedge clk); #1;
    chk("i_cmd_read", mem_read, 1);
    chk("i_cmd_addr", mem_addr, 28'h0000010);
    wait_rdy(0, rdv);
    i_read = 0;
    repeat (3) @(posedge clk); #1;
    chk("i_rdata_dead", rdv[15:0], 16'hDEAD);
    chk("i_ready_pulses", n_ir - b0, 1);
    chk("i_gnt_cnt", gnt_cnt_i, 1);
    b0 = n_dr; b1 = n_mrd;
    d_addr = 28'h0000040; d_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321; d_write = 1;
    @(posedge clk); #1;
    chk("d_cmd_write", mem_write, 1);
    chk("d_cmd_wdata", mem_wdata, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
    wait_rdy(1, rdv);
    d_write = 0;
    repeat (3) @(posedge clk); #1;
    chk("d_ready_pulses", n_dr - b0, 1);
    chk("d_no_mem_read", n_mrd - b1, 0);
    chk("d_gnt_cnt", gnt_cnt_d, 1);
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    bo = ord.size(); bg = gaps.size();
    i_addr = 28'h0000111; i_read = 1; d_addr = 28'h0000222; d_read = 1;
    b2 = 0;
    while (ord.size() < bo + 4 && b2 < 200) begin @(negedge clk); b2++; end
    chk("pair_count", ord.size() >= bo + 4, 1);
    @(posedge clk); #1;
    i_read = 0; d_read = 0;
    chk("order0_d", ord[bo], 1);
    chk("order1_i", ord[bo + 1], 0);
    chk("order2_d", ord[bo + 2], 1);
    chk("order3_i", ord[bo + 3], 0);
    chk("gap1", gaps[bg + 1], 1);
    chk("gap2", gaps[bg + 2], 1);
    chk("gap3", gaps[bg + 3], 1);
    repeat (3) @(posedge clk); #1;
    sci = gnt_cnt_i; scd = gnt_cnt_d; b0 = n_ir; b1 = n_dr;
    @(negedge clk) stray = 1;
    @(negedge clk) stray = 0;
    repeat (3) @(posedge clk); #1;
    chk("stray_i_ready", n_ir - b0, 0);
    chk("stray_d_ready", n_dr - b1, 0);
    chk("stray_cnt_i", gnt_cnt_i, sci);
    chk("stray_cnt_d", gnt_cnt_d, scd);
    chk("stray_mem_read", mem_read, 0);
    d_addr = 28'h0000055; d_wdata = 128'hA5A5; d_write = 1;
    @(posedge clk); #1;
    chk("busy_d_write", mem_write, 1);
    #2 rst = 0;
    #1;
    chk("async_rst_write", mem_write, 0);
    chk("async_rst_cnt_d", gnt_cnt_d, 0);
    chk("async_rst_cnt_i", gnt_cnt_i, 0);
    d_write = 0; i_addr = 28'h0000077; i_read = 1;
    @(posedge clk); #1;
    rst = 1;
    bo = ord.size();
    fork
      run_i(28'h0000077);
      begin @(posedge clk); #1; run_d(28'h0000088, 128'h5A5A, 0, 1); end
    join
    chk("post_rst_first_i", ord[bo], 0);
    chk("post_rst_then_d", ord[bo + 1], 1);
    repeat (2) @(posedge clk); #1;
    force dut.u_cnt_d.r_cnt = 16'hFFFE;
    load_req = 1; chk_en = 0;
    @(posedge clk); #1;
    release dut.u_cnt_d.r_cnt;
    load_req = 0; chk_en = 1;
    repeat (3) run_d(28'h0000099, 128'h77, 1, 0);
    repeat (2) @(posedge clk); #1;
    chk("sat_cnt_d", gnt_cnt_d, 16'hFFFF);
    d_addr = 28'h00000AB; d_wdata = 128'hBEEF; d_read = 1; d_write = 1;
    @(posedge clk); #1;
    chk("proto_write_only", mem_write, 1);
    chk("proto_no_read", mem_read, 0);
    wait_rdy(1, rdv);
    d_read = 0; d_write = 0;
    @(posedge clk); #1;
    chk("proto_err_set", dut.r_proto_err, 1);
    chk("proto_sat_hold", gnt_cnt_d, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
